// File: rtl/int_ctrl.sv
// Eight-source edge-triggered interrupt controller with a memory-mapped register file.
// Define INTC_SYNC_EN to add a two-flop synchroniser per irq line ahead of edge detection.
module int_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  irq,
  output logic        INT,
  input  logic        intack,
  output logic [15:0] vector,
  input  logic        cs,
  input  logic [1:0]  address,
  input  logic [15:0] data_in,
  input  logic        memwt,
  output logic [15:0] data_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  localparam logic [1:0] A_MASK    = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_STATUS  = 2'd2;
  localparam logic [1:0] A_EOI     = 2'd3;

  logic [1:0]  r_state;
  logic [7:0]  r_mask;
  logic [7:0]  r_pending;
  logic [2:0]  r_idx;
  logic [7:0]  r_irqHist;
  logic [1:0]  r_primeCnt;
  logic [7:0]  w_irqSampled;
  logic [7:0]  w_edge;
  logic [7:0]  w_req;
  logic [7:0]  w_clr;
  logic [2:0]  w_lowIdx;
  logic        w_primed;
  logic        w_wrMask;
  logic        w_wrPending;
  logic        w_wrEoi;
  logic        w_ackTaken;
  logic        w_unusedData;

`ifdef INTC_SYNC_EN
  // Edge detection waits until the synchroniser holds real post-reset samples.
  localparam logic [1:0] PRIME_CYCLES = 2'd3;
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irqSampled = r_sync2;
`else
  localparam logic [1:0] PRIME_CYCLES = 2'd1;
  assign w_irqSampled = irq;
`endif

  assign w_primed     = (r_primeCnt == PRIME_CYCLES);
  assign w_edge       = w_primed ? (w_irqSampled & ~r_irqHist) : 8'h00;
  assign w_req        = r_pending & ~r_mask;
  assign w_wrMask     = cs & memwt & (address == A_MASK);
  assign w_wrPending  = cs & memwt & (address == A_PENDING);
  assign w_wrEoi      = cs & memwt & (address == A_EOI);
  assign w_ackTaken   = (r_state == S_REQ) & intack;
  assign w_unusedData = &{1'b0, data_in[15:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irqHist  <= 8'h00;
      r_primeCnt <= 2'd0;
    end else begin
      r_irqHist <= w_irqSampled;
      if (!w_primed) begin
        r_primeCnt <= r_primeCnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_lowIdx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_req[i]) begin
        w_lowIdx = i[2:0];
      end
    end
  end

  // A new edge overrides any clear aimed at the same bit in the same cycle.
  always_comb begin
    w_clr = 8'h00;
    if (w_wrPending) begin
      w_clr = data_in[7:0];
    end
    if (w_ackTaken) begin
      w_clr = w_clr | (8'h01 << r_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask    <= 8'hFF;
      r_pending <= 8'h00;
    end else begin
      if (w_wrMask) begin
        r_mask <= data_in[7:0];
      end
      r_pending <= (r_pending & ~w_clr) | w_edge;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req != 8'h00) begin
            r_idx   <= w_lowIdx;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (intack) begin
            r_state <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (w_wrEoi) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // INT decodes straight from state so an asynchronous reset drops it at once.
  assign INT    = (r_state == S_REQ);
  assign vector = intack ? {13'b0, r_idx} : 16'h0000;

  always_comb begin
    data_out = 16'h0000;
    case (address)
      A_MASK:    data_out = {8'h00, r_mask};
      A_PENDING: data_out = {8'h00, r_pending};
      A_STATUS:  data_out = {7'b0, (r_state == S_SERVICE), 5'b0, r_idx};
      A_EOI:     data_out = 16'h0000;
      default:   data_out = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl; delivered vectors are checked against a queue of
// expected vectors pushed when the interrupt stimulus is applied.
module tb_int_ctrl;

`ifdef INTC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq;
  logic        INT;
  logic        intack;
  logic [15:0] vector;
  logic        cs;
  logic [1:0]  address;
  logic [15:0] data_in;
  logic        memwt;
  logic [15:0] data_out;

  int testsRun;
  int testsFailed;
  logic [15:0] expQ[$];

  int_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq      (irq),
    .INT      (INT),
    .intack   (intack),
    .vector   (vector),
    .cs       (cs),
    .address  (address),
    .data_in  (data_in),
    .memwt    (memwt),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [15:0] data);
    cs      = 1'b1;
    memwt   = 1'b1;
    address = addr;
    data_in = data;
    tick();
    cs      = 1'b0;
    memwt   = 1'b0;
    data_in = 16'h0000;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [15:0] data);
    address = addr;
    #1;
    data = data_out;
  endtask

  task automatic waitInt(input string name);
    int n;
    n = 0;
    while (INT !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    testsRun++;
    if (INT !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL %s: INT timeout, got %b want 1", name, INT);
    end
  endtask

  task automatic ackAndScore(input string name);
    logic [15:0] expVec;
    intack = 1'b1;
    #1;
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL %s: vector 0x%04h delivered with empty scoreboard", name, vector);
    end else begin
      expVec = expQ.pop_front();
      if (vector !== expVec) begin
        testsFailed++;
        $display("[TB] FAIL %s: vector got 0x%04h want 0x%04h", name, vector, expVec);
      end
    end
    tick();
    intack = 1'b0;
  endtask

  task automatic checkVal(input string name, input logic [15:0] got, input logic [15:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%04h want 0x%04h", name, got, want);
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b0; irq = 8'h00; intack = 1'b0;
    cs = 1'b0; memwt = 1'b0; address = 2'd0; data_in = 16'h0000;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    readReg(2'd0, d); checkVal("reset_mask", d, 16'h00FF);
    readReg(2'd1, d); checkVal("reset_pending", d, 16'h0000);
    readReg(2'd2, d); checkVal("reset_status", d, 16'h0000);
    readReg(2'd3, d); checkVal("reset_eoi_read", d, 16'h0000);
    checkVal("reset_int", {15'b0, INT}, 16'h0000);
    checkVal("reset_vector", vector, 16'h0000);
  endtask

  task automatic test_basic();
    logic [15:0] d;
    writeReg(2'd0, 16'h00FE);
    irq[0] = 1'b1;
    repeat (LAT) tick();
    irq[0] = 1'b0;
    readReg(2'd1, d); checkVal("basic_pending_set", d, 16'h0001);
    checkVal("basic_int_not_yet", {15'b0, INT}, 16'h0000);
    tick();
    checkVal("basic_int_asserted", {15'b0, INT}, 16'h0001);
    readReg(2'd2, d); checkVal("basic_status_req", d, 16'h0000);
    expQ.push_back(16'h0000);
    ackAndScore("basic_vector");
    readReg(2'd1, d); checkVal("basic_pending_cleared", d, 16'h0000);
    checkVal("basic_int_dropped", {15'b0, INT}, 16'h0000);
    readReg(2'd2, d); checkVal("basic_status_service", d, 16'h0100);
    writeReg(2'd3, 16'h1234);
    readReg(2'd2, d); checkVal("basic_status_after_eoi", d, 16'h0000);
  endtask

  task automatic test_priority();
    logic [15:0] d;
    writeReg(2'd0, 16'h0000);
    irq = 8'h24;
    expQ.push_back(16'h0002);
    expQ.push_back(16'h0005);
    repeat (LAT) tick();
    irq = 8'h00;
    waitInt("prio_first_int");
    checkVal("prio_vector_idle_low", vector, 16'h0000);
    ackAndScore("prio_first_vector");
    writeReg(2'd3, 16'h0000);
    waitInt("prio_second_int");
    ackAndScore("prio_second_vector");
    writeReg(2'd3, 16'h0000);
    readReg(2'd1, d); checkVal("prio_pending_empty", d, 16'h0000);
  endtask

  task automatic test_mask();
    logic [15:0] d;
    writeReg(2'd0, 16'h00FF);
    irq[3] = 1'b1;
    repeat (LAT) tick();
    irq[3] = 1'b0;
    readReg(2'd1, d); checkVal("mask_pending_set", d, 16'h0008);
    repeat (3) tick();
    checkVal("mask_int_held_off", {15'b0, INT}, 16'h0000);
    writeReg(2'd0, 16'h00F7);
    tick();
    checkVal("mask_int_after_unmask", {15'b0, INT}, 16'h0001);
    expQ.push_back(16'h0003);
    ackAndScore("mask_vector");
    writeReg(2'd3, 16'h0000);
  endtask

  task automatic test_w1c_race();
    logic [15:0] d;
    writeReg(2'd0, 16'h0000);
    irq[6] = 1'b1;
    expQ.push_back(16'h0006);
    repeat (LAT) tick();
    irq[6] = 1'b0;
    waitInt("race_int");
    ackAndScore("race_vector6");
    irq[1] = 1'b1;
    repeat (LAT - 1) tick();
    writeReg(2'd1, 16'h0002);
    irq[1] = 1'b0;
    readReg(2'd1, d); checkVal("race_edge_wins", d, 16'h0002);
    readReg(2'd2, d); checkVal("race_status", d, 16'h0106);
    repeat (2) tick();
    checkVal("race_int_low_in_service", {15'b0, INT}, 16'h0000);
    writeReg(2'd3, 16'h0000);
    tick();
    checkVal("race_int_after_eoi", {15'b0, INT}, 16'h0001);
    expQ.push_back(16'h0001);
    ackAndScore("race_vector1");
    writeReg(2'd3, 16'h0000);
  endtask

  task automatic test_w1c_in_req();
    logic [15:0] d;
    irq[7] = 1'b1;
    expQ.push_back(16'h0007);
    repeat (LAT) tick();
    irq[7] = 1'b0;
    waitInt("req_w1c_int");
    writeReg(2'd1, 16'h0080);
    readReg(2'd1, d); checkVal("req_w1c_pending", d, 16'h0000);
    checkVal("req_w1c_int_kept", {15'b0, INT}, 16'h0001);
    ackAndScore("req_w1c_vector");
    writeReg(2'd3, 16'h0000);
  endtask

  task automatic test_reset_in_req();
    logic [15:0] d;
    writeReg(2'd0, 16'h0000);
    irq[4] = 1'b1;
    repeat (LAT) tick();
    waitInt("rst_int");
    rst_n = 1'b0;
    #1;
    checkVal("rst_int_async", {15'b0, INT}, 16'h0000);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    writeReg(2'd0, 16'h0000);
    repeat (6) tick();
    readReg(2'd1, d); checkVal("rst_no_edge_pending", d, 16'h0000);
    checkVal("rst_int_stays_low", {15'b0, INT}, 16'h0000);
    irq[4] = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_w1c_race();
    test_w1c_in_req();
    test_reset_in_req();
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: %0d vectors left, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
